// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and types: NOP encoding, word width, fetch FSM states
// and the {word, pc+4} entry carried through the prefetch FIFO.
package pipeline_pkg;
    localparam int WORD_W = 32;
    localparam logic [0:WORD_W-1] NOP_INSTR = 32'h5400_0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } fetch_state_e;

    typedef struct packed {
        logic [0:WORD_W-1] word;
        logic [0:WORD_W-1] pc4;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH entries of {word, pc+4}, wrapping pointers, occupancy count
// and a synchronous flush that wins over push and pop.
module fetch_fifo
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_flush,
    input  logic          i_push,
    input  fetch_entry_t  i_wdata,
    input  logic          i_pop,
    output fetch_entry_t  o_head,
    output logic [CW-1:0] o_count,
    output logic          o_empty
);
    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push = i_push && !i_flush;
    assign w_pop  = i_pop && !i_flush && (r_count != '0);

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch: sequential req/ack fetch into fetch_fifo, one-per-cycle output slot,
// flush/redirect from decode. Define PREFETCH_BYPASS_EN to let words skip an empty FIFO.
module instr_prefetch
    import pipeline_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [0:WORD_W-1] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_lock,
    input  logic              jump_or_branch,
    input  logic [0:WORD_W-1] target,
    output logic              imem_req,
    output logic [0:WORD_W-1] imem_addr,
    input  logic              imem_ack,
    input  logic [0:WORD_W-1] imem_rdata,
    output logic [0:WORD_W-1] instr,
    output logic [0:WORD_W-1] pc_plus_four,
    output logic              instr_valid
);
    localparam int            CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_state_e      r_state;
    fetch_state_e      w_next;
    logic [0:WORD_W-1] r_fetch_pc;
    logic [0:WORD_W-1] r_stale_addr;
    logic [0:WORD_W-1] r_instr;
    logic [0:WORD_W-1] r_pc4;
    logic              r_valid;
    logic [0:WORD_W-1] w_pc_inc;
    logic              w_acked;
    logic              w_take;
    logic              w_bypass;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic [CW-1:0]     w_count_next;
    fetch_entry_t      w_head;
    fetch_entry_t      w_wdata;

    assign w_pc_inc = r_fetch_pc + 32'd4;
    assign w_acked  = (r_state == REQ) && imem_ack;
    assign w_take   = w_acked && !jump_or_branch;
    assign w_pop    = !jump_or_branch && !reg_lock && !w_empty;
`ifdef PREFETCH_BYPASS_EN
    assign w_bypass = w_take && w_empty && !reg_lock;
`else
    assign w_bypass = 1'b0;
`endif
    assign w_push       = w_take && !w_bypass;
    assign w_count_next = w_count + CW'(w_push) - CW'(w_pop);
    assign w_wdata      = '{word: imem_rdata, pc4: w_pc_inc};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_flush (jump_or_branch),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!jump_or_branch && w_count != FULL_CNT) w_next = REQ;
            // A redirect that races the ack simply drops the word and refetches at target.
            REQ: begin
                if (imem_ack)
                    w_next = (jump_or_branch || w_count_next != FULL_CNT) ? REQ : IDLE;
                else if (jump_or_branch)
                    w_next = DISCARD;
            end
            DISCARD: if (imem_ack) w_next = REQ;
            default: w_next = IDLE;
        endcase
    end

    // fetch_pc takes the target immediately; the stale request address lives in r_stale_addr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_fetch_pc   <= RESET_PC;
            r_stale_addr <= RESET_PC;
        end else begin
            r_state <= w_next;
            if (jump_or_branch)
                r_fetch_pc <= target;
            else if (w_acked)
                r_fetch_pc <= w_pc_inc;
            if (r_state == REQ && !imem_ack && jump_or_branch)
                r_stale_addr <= r_fetch_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr <= NOP_INSTR;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (jump_or_branch) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (!reg_lock) begin
            if (!w_empty) begin
                r_instr <= w_head.word;
                r_pc4   <= w_head.pc4;
                r_valid <= 1'b1;
            end else if (w_bypass) begin
                r_instr <= imem_rdata;
                r_pc4   <= w_pc_inc;
                r_valid <= 1'b1;
            end else begin
                r_instr <= NOP_INSTR;
                r_valid <= 1'b0;
            end
        end
    end

    assign imem_req     = (r_state != IDLE);
    assign imem_addr    = (r_state == DISCARD) ? r_stale_addr : r_fetch_pc;
    assign instr        = r_instr;
    assign pc_plus_four = r_pc4;
    assign instr_valid  = r_valid;
endmodule

// File: doc/instr_prefetch.md
# instr_prefetch

Instruction prefetch unit that feeds the decode stage of the five-stage pipeline. It fetches sequential instruction words from instruction memory over a req/ack handshake and buffers them with their PC+4 in a small FIFO. It presents one instruction per cycle to decode, holds it while decode asserts `reg_lock`, and flushes and redirects when decode signals a taken jump or branch.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.

- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `reg_lock`  in  1  decode stall; hold the output slot.
- `jump_or_branch`  in  1  redirect strobe from decode, one cycle.
- `target`  in  [0:31]  redirect address, valid with `jump_or_branch`.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  [0:31]  fetch address; stable while `imem_req`=1.
- `imem_ack`  in  1  request complete; `imem_rdata` valid this cycle.
- `imem_rdata`  in  [0:31]  fetched word.
- `instr`  out  [0:31]  instruction to decode, registered.
- `pc_plus_four`  out  [0:31]  address of `instr` + 4, registered.
- `instr_valid`  out  1  `instr` is a real fetched word, not a bubble.

## Operation
- **State.** Fetch PC register `fetch_pc`. FIFO of {word, pc+4} with `count` in 0..DEPTH. Output slot {`instr`, `pc_plus_four`, `instr_valid`}.
- **Fetch FSM states:**
  - IDLE: `imem_req`=0. Go to REQ when `count` < DEPTH and no redirect is active.
  - REQ: `imem_req`=1, `imem_addr`=`fetch_pc`.
    - On `imem_ack`: push {`imem_rdata`, `fetch_pc`+4} and set `fetch_pc` += 4.
    - Then stay in REQ if room remains after this cycle's push/pop; otherwise go to IDLE.
  - DISCARD: `imem_req`=1 at the stale address. On `imem_ack`, drop the data, set `fetch_pc` = latched target, and go to REQ.
- **At most one request outstanding.** A request is only issued with `count` < DEPTH, so a push never overflows.
- **Output slot (when `reg_lock`=0):**
  - FIFO non-empty: pop the head into the slot and set `instr_valid`=1.
  - FIFO empty: load `instr`=NOP_INSTR, set `instr_valid`=0, and hold `pc_plus_four`.
- **Output slot (when `reg_lock`=1):** all three outputs hold; no pop. Fetching continues until the FIFO is full.
- **Simultaneous push and pop:** `count` is unchanged. A push is never dropped at `count`=DEPTH because a pop frees the entry in the same edge.
- **Redirect (`jump_or_branch`=1):** has priority over `reg_lock` and any pop.
  - FIFO is flushed (`count`=0).
  - Output slot becomes NOP_INSTR with `instr_valid`=0; `pc_plus_four` holds.
  - `fetch_pc` = `target`.
  - If the FSM is in REQ without `imem_ack` this cycle, go to DISCARD and keep `imem_addr` stable.
  - If `imem_ack` arrives in the same cycle, drop the data and go to REQ at `target`.
  - A redirect while in DISCARD replaces the latched target.
- **Arithmetic.** All PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 = 0. Bit 0 is the MSB.

## Timing
- **Reset values:** `imem_req`=0, `imem_addr`=RESET_PC, `instr`=NOP_INSTR, `pc_plus_four`=0, `instr_valid`=0, `count`=0, FSM in IDLE.
- **Reset mid-request:** `imem_req` drops asynchronously, and any ack in flight is abandoned. Instruction memory must tolerate this.
- **Latency, zero-wait memory:** first request in the cycle after reset deasserts. Push at edge +1, output slot valid at edge +2.
- **Steady-state throughput:** one instruction per cycle with zero-wait memory.
- **Redirect penalty:** the `target` word reaches the output slot 2 cycles after the redirect edge with zero-wait memory. Add 1 cycle plus the remaining memory latency when a discard is pending.

## Configuration
- **`PREFETCH_BYPASS_EN` defined:** when the FIFO is empty, `reg_lock`=0 and `imem_ack`=1 with no redirect, the word goes straight into the output slot at that edge and skips the FIFO. First-instruction and redirect latency each drop by one cycle.
- **`PREFETCH_BYPASS_EN` undefined:** every word passes through the FIFO.
- Fetch order and `instr_valid` semantics are identical in both builds.

## Structure
- **`pipeline_pkg`** holds:
  - `NOP_INSTR` = 32'h5400_0000;
  - the fetch FSM state enum (IDLE, REQ, DISCARD);
  - the width constant `WORD_W` = 32.
- **Sub-module `fetch_fifo`** holds storage for DEPTH × 64 bits, wrapping read/write pointers, `count`, and a synchronous flush. Pointers wrap modulo DEPTH.
- **Top** holds the FSM, `fetch_pc`, the output slot, and the redirect logic.

## Test plan
- **Reset, sequential fetch:** zero-wait memory, `RESET_PC`=0. Require `instr_valid` rising at cycle 2 (cycle 1 with bypass), then words from addresses 0, 4, 8 with `pc_plus_four` = 4, 8, 12.
- **Stall fill:** `reg_lock`=1 for 10 cycles. Require the output to hold, `imem_req` to drop once `count`=4, and 4 buffered words to drain in order on release with no loss.
- **Redirect with pending request:** 3-cycle memory latency, `jump_or_branch` with `target`=32'h100 one cycle after the request.
  - Require `imem_addr` stable until ack and the stale word dropped.
  - Require the next request at 32'h100 and the next valid `instr` to come from 32'h100 with `pc_plus_four`=32'h104.
- **Redirect and ack same cycle, FIFO full, `reg_lock`=1:** require a flush, `instr_valid`=0 next cycle, and the acked word never to appear.
- **Wrap-around:** `RESET_PC`=32'hFFFF_FFF8. Require `pc_plus_four` sequence FFFF_FFFC, 0000_0000, 0000_0004.
- **Async reset mid-request:** assert `reset` while `imem_req`=1. Require `imem_req`=0 with no clock edge, and fetch to restart at `RESET_PC`.
